// File: rtl/muldiv_if.sv
// muldiv_if: request and register-file write-back bundle for muldiv_unit
interface muldiv_if;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src1;
  logic [31:0] src2;
  logic [4:0]  dst;
  logic        busy;
  logic        done;
  logic [31:0] wr;
  logic [4:0]  wa;
  logic        wren;
  modport master (output start, op, src1, src2, dst, input busy, done, wr, wa, wren);
  modport slave  (input start, op, src1, src2, dst, output busy, done, wr, wa, wren);
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: 32-cycle iterative unsigned multiply/divide with register-file write-back
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input logic      clk,
  input logic      rstd,
  muldiv_if.slave  bus
);
  typedef enum logic [1:0] {IDLE, RUN, WB} state_t;
  state_t            st;
  logic [5:0]        cnt;
  logic [1:0]        opq;
  logic [4:0]        dq;
  logic [XLEN-1:0]   m;
  logic [2*XLEN-1:0] acc, acc_n;
  logic [XLEN:0]     sum, sh, diff;
  logic              ge;
  // acc holds {product hi, multiplier} for multiply and {remainder, quotient} for divide
  always_comb begin
    sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, m} : '0);
    sh    = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
    diff  = sh - {1'b0, m};
    ge    = !diff[XLEN];
    acc_n = opq[1] ? {ge ? diff[XLEN-1:0] : sh[XLEN-1:0], acc[XLEN-2:0], ge}
                   : {sum, acc[XLEN-1:1]};
  end
  always_ff @(posedge clk) begin
    if (rstd) begin
      st       <= IDLE;
      cnt      <= '0;
      opq      <= '0;
      dq       <= '0;
      m        <= '0;
      acc      <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.wr   <= '0;
      bus.wa   <= '0;
      bus.wren <= 1'b1;
    end else begin
      case (st)
        IDLE: if (bus.start) begin
          st       <= RUN;
          cnt      <= '0;
          opq      <= bus.op;
          dq       <= bus.dst;
          m        <= bus.op[1] ? bus.src2 : bus.src1;
          acc      <= {{XLEN{1'b0}}, bus.op[1] ? bus.src1 : bus.src2};
          bus.busy <= 1'b1;
        end
        RUN: begin
          acc <= acc_n;
          cnt <= cnt + 6'd1;
          if (cnt == 6'd31) begin
            st       <= WB;
            bus.done <= 1'b1;
            bus.wr   <= opq[0] ? acc_n[2*XLEN-1:XLEN] : acc_n[XLEN-1:0];
            bus.wa   <= dq;
            bus.wren <= (dq == 5'd0);
          end
        end
        WB: begin
          st       <= IDLE;
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          bus.wr   <= '0;
          bus.wa   <= '0;
          bus.wren <= 1'b1;
        end
        default: st <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state changes on posedge clk.
REQ-003 SHALL have port rstd  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port start  input  1  request; sampled only in IDLE.
REQ-005 SHALL have port op  input  2  00 MULLO, 01 MULHI (unsigned), 10 DIVU, 11 REMU.
REQ-006 SHALL have port src1  input  32  first operand, driven from register-file read port 1.
REQ-007 SHALL have port src2  input  32  second operand, driven from register-file read port 2.
REQ-008 SHALL have port dst  input  5  destination register index.
REQ-009 SHALL have port busy  output  1  high while an operation is in RUN or WB.
REQ-010 SHALL have port done  output  1  one-cycle completion pulse.
REQ-011 SHALL have port wr  output  32  write data to the register file.
REQ-012 SHALL have port wa  output  5  write address to the register file.
REQ-013 SHALL have port wren  output  1  register-file write enable, active-low (0 = write).

Function
REQ-014 SHALL implement a three-state FSM: IDLE, RUN, WB.
REQ-015 SHALL accept a request on a posedge with state IDLE and start=1: latch op, src1, src2 and dst, clear the 6-bit iteration counter, and go to RUN.
REQ-016 SHALL ignore start in RUN and WB, with no queuing and no effect on the operation in flight.
REQ-017 SHALL ignore src1, src2, op and dst changes after acceptance.
REQ-018 SHALL, in RUN, perform one iteration per cycle for exactly 32 cycles, then go to WB.
REQ-019 SHALL implement MULLO/MULHI as an unsigned shift-add multiply producing a 64-bit product; MULLO returns bits [31:0], MULHI returns bits [63:32].
REQ-020 SHALL implement DIVU/REMU as an unsigned restoring divide; DIVU returns the quotient, REMU returns the remainder.
REQ-021 SHALL, on divide by zero, return 0xFFFFFFFF for DIVU and src1 for REMU, with the same 32-cycle latency.
REQ-022 SHALL, in WB for exactly one cycle, drive done=1, wr=result, wa=latched dst and wren=0, then return to IDLE.
REQ-023 SHALL, if latched dst=0, keep wren=1 in WB (r0 is protected) while done still pulses and wr/wa still carry result/0.
REQ-024 SHALL hold wren=1, done=0 and wr, wa at 0 in IDLE and RUN.
REQ-025 SHALL drive busy=1 in RUN and WB and busy=0 in IDLE.
REQ-026 SHALL have a latency from the acceptance edge E0 to WB of 32 edges: WB is active between E32 and E33; IDLE resumes after E33; the earliest next acceptance is at E34.
REQ-027 SHALL register all outputs, with no combinational path from any input to any output.

Reset
REQ-028 SHALL, on a posedge with rstd=1, go to IDLE and clear the counter and all datapath registers.
REQ-029 SHALL reset outputs to busy=0, done=0, wr=0, wa=0 and wren=1.
REQ-030 SHALL, on reset in RUN or WB, abandon the operation: no register-file write, no done pulse, and start ignored during that reset cycle.
REQ-031 SHALL give rstd priority over start on the same edge.

Verification
REQ-032 SHALL cover: MULLO src1=0x00010000, src2=0x00010000, dst=5 -> at E32..E33: wr=0x00000000, wa=5, wren=0, done=1; then the same operands with MULHI -> wr=0x00000001.
REQ-033 SHALL cover: DIVU 100/7, dst=3 -> wr=14; REMU 100/7 -> wr=2; busy high for exactly 33 cycles each.
REQ-034 SHALL cover: DIVU 0x1234/0 -> wr=0xFFFFFFFF; REMU 0x1234/0 -> wr=0x00001234; latency unchanged.
REQ-035 SHALL cover: start pulsed with different operands 5 cycles into RUN -> ignored, and the original result is written.
REQ-036 SHALL cover: rstd=1 for one cycle at RUN cycle 10 -> busy=0 next cycle, and no wren=0 or done pulse before a new start.
REQ-037 SHALL cover: MULLO 3*4 with dst=0 -> done=1, wr=12, wa=0 and wren stays 1 throughout.
